cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller that sequences the 8-bit single-cycle CPU core through a per-instruction clock enable. It accepts RUN / STEP / STOP / CLEAR commands, stops execution on HALT, a PC breakpoint, an instruction-count timeout or an explicit STOP, and reports the stop cause. It sits between the debug/test host and the `cpu` core's enable and reset inputs, and keeps a retired-instruction counter.

## Interface
- `PC_W`, 8, width of CPU program counter
- `CNT_W`, 16, width of retired-instruction counter
- `TIMEOUT`, 50, max instructions per RUN before forced stop (≥1)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command strobe
- `cmd_op`  in  2  0=RUN, 1=STEP, 2=STOP, 3=CLEAR
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at clock edge
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  PC_W  breakpoint PC
- `cpu_pc`  in  PC_W  current CPU PC (instruction about to execute)
- `cpu_halted`  in  1  CPU has executed HALT
- `cpu_en`  out  1  CPU commits one instruction at this edge when 1 (combinational)
- `cpu_rst`  out  1  registered reset to CPU core
- `state`  out  2  0=IDLE, 1=RUN, 2=STEP, 3=HALTED
- `cycle_cnt`  out  CNT_W  instructions retired since reset/CLEAR, saturating
- `done`  out  1  one-cycle stop pulse (registered)
- `done_cause`  out  2  0=HALT, 1=BREAKPOINT, 2=TIMEOUT, 3=STOP/STEP-complete; held until next `done`

## Operation
- FSM states IDLE, RUN, STEP, HALTED.
- `cmd_ready` = 1 in IDLE, RUN, HALTED; 0 in STEP.
- IDLE: RUN → RUN (clear `run_cnt`, set `bp_skip`); STEP → STEP; CLEAR → IDLE with CLEAR actions; STOP ignored.
- RUN: `stop_now` = `cpu_halted` | (`bp_en` & `cpu_pc==bp_addr` & !`bp_skip`) | (`run_cnt==TIMEOUT`) | (accepted STOP). `cpu_en` = !`stop_now`. On `stop_now`: next state HALTED if `cpu_halted`, else IDLE; `done` next cycle. Cause priority HALT > BREAKPOINT > TIMEOUT > STOP. RUN/STEP/CLEAR commands in RUN accepted and dropped.
- `bp_skip` set on RUN entry, cleared after first RUN cycle: resuming from a breakpoint executes that instruction.
- `run_cnt` increments on every `cpu_en` cycle in RUN.
- STEP: single cycle; `cpu_en` = !`cpu_halted`; next state HALTED if `cpu_halted` else IDLE; `done` with cause HALT or STEP(3). Breakpoint not checked.
- HALTED: only CLEAR acts (→ IDLE); RUN/STEP/STOP accepted and dropped, no `done`.
- CLEAR actions: `cpu_rst`=1 for exactly one cycle after accept, `cycle_cnt`=0, `done_cause` unchanged.
- `cycle_cnt` += 1 on every cycle with `cpu_en`=1; saturates at 2^CNT_W−1.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `cpu_en`=0, `cpu_rst`=1, `done`=0, `done_cause`=0, `cycle_cnt`=0, `run_cnt`=0, `bp_skip`=0. `cpu_rst` drops at first edge after `rst_n` release.
- Command accepted at edge E → new state effective cycle E+1; first `cpu_en` in cycle E+1.
- Stop detected in cycle N: `cpu_en`=0 in cycle N (the stopping instruction is not executed), state and `done`=1 in cycle N+1.
- RUN with no stop: exactly TIMEOUT instructions retired, `done` cause TIMEOUT.
- Reset mid-RUN: immediate return to reset values; no `done`.

## Test plan
- Reset then RUN; `cpu_halted` rises after 6 enabled cycles → `cycle_cnt`=6, state HALTED, `done` one cycle, cause 0; subsequent RUN dropped.
- `bp_en`=1, `bp_addr`=0x04, RUN; `cpu_pc` reaches 0x04 → `cpu_en`=0 that cycle, IDLE, cause 1; second RUN executes 0x04 (no immediate re-stop).
- RUN with `TIMEOUT`=50, CPU never halts → exactly 50 `cpu_en` cycles, cause 2, state IDLE.
- STOP accepted same cycle `cpu_halted`=1 → cause 0, state HALTED; STOP alone in RUN → cause 3, `cpu_en`=0 in accept cycle.
- Three STEPs from IDLE → 3 `done` pulses, cause 3, `cycle_cnt`=3, `cmd_ready`=0 during each STEP cycle.
- CLEAR from HALTED → `cpu_rst`=1 one cycle, `cycle_cnt`=0, IDLE; `rst_n` pulse mid-RUN → all outputs at reset values, `cpu_rst`=1.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: bundles the host command channel, breakpoint setup,
// CPU status inputs and the controller's outputs into one connection.
//   master : host/CPU side; drives commands, breakpoint and CPU status,
//            and observes enable, reset, state, counter and done status.
//   slave  : the run controller.
// Parameters: PC_W (program counter width), CNT_W (retired counter width).
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  cpu_pc;
  logic             cpu_halted;
  logic             cpu_en;
  logic             cpu_rst;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done;
  logic [1:0]       done_cause;

  modport master (
    output cmd_valid, cmd_op, bp_en, bp_addr, cpu_pc, cpu_halted,
    input  cmd_ready, cpu_en, cpu_rst, state, cycle_cnt, done, done_cause
  );

  modport slave (
    input  cmd_valid, cmd_op, bp_en, bp_addr, cpu_pc, cpu_halted,
    output cmd_ready, cpu_en, cpu_rst, state, cycle_cnt, done, done_cause
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences a single-cycle CPU through a per-instruction
// clock enable. Accepts RUN/STEP/STOP/CLEAR commands, stops on HALT,
// PC breakpoint, per-RUN instruction timeout or explicit STOP, reports the
// stop cause and counts retired instructions.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cpu_run_ctrl_if slave (command handshake, breakpoint, CPU
//           status in; cpu_en, cpu_rst, state, cycle_cnt, done, done_cause out)
module cpu_run_ctrl #(
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [1:0] CAUSE_HALT = 2'd0;
  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_TO   = 2'd2;
  localparam logic [1:0] CAUSE_STOP = 2'd3;

  // run_cnt only ever needs to reach TIMEOUT
  localparam int               RUN_W     = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
  logic             bp_skip_reg, bp_skip_next;
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic             cpu_rst_reg;
  logic             done_reg, done_next;
  logic [1:0]       done_cause_reg, done_cause_next;

  logic             cmd_ready;
  logic             cmd_fire;
  logic             cpu_en;
  logic             clear_go;
  logic             bp_hit;
  logic             timeout_hit;
  logic             stop_cmd;
  logic             stop_now;
  logic [PC_W-1:0]  pc;

  assign pc          = bus.cpu_pc;
  assign cmd_ready   = (state_reg != S_STEP);
  assign cmd_fire    = bus.cmd_valid && cmd_ready;
  // bp_skip masks the breakpoint on the first RUN cycle so a resume from a
  // breakpoint executes the instruction it stopped on.
  assign bp_hit      = bus.bp_en && (pc == bus.bp_addr) && !bp_skip_reg;
  assign timeout_hit = (run_cnt_reg == RUN_LIMIT);
  assign stop_cmd    = cmd_fire && (bus.cmd_op == OP_STOP);
  assign stop_now    = bus.cpu_halted || bp_hit || timeout_hit || stop_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      run_cnt_reg    <= '0;
      bp_skip_reg    <= 1'b0;
      cycle_cnt_reg  <= '0;
      cpu_rst_reg    <= 1'b1;
      done_reg       <= 1'b0;
      done_cause_reg <= CAUSE_HALT;
    end else begin
      state_reg      <= state_next;
      run_cnt_reg    <= run_cnt_next;
      bp_skip_reg    <= bp_skip_next;
      cpu_rst_reg    <= clear_go;
      done_reg       <= done_next;
      done_cause_reg <= done_cause_next;
      if (clear_go)
        cycle_cnt_reg <= '0;
      else if (cpu_en && (cycle_cnt_reg != CNT_MAX))
        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    run_cnt_next    = run_cnt_reg;
    bp_skip_next    = bp_skip_reg;
    done_next       = 1'b0;
    done_cause_next = done_cause_reg;
    cpu_en          = 1'b0;
    clear_go        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (cmd_fire) begin
          case (bus.cmd_op)
            OP_RUN: begin
              state_next   = S_RUN;
              run_cnt_next = '0;
              bp_skip_next = 1'b1;
            end
            OP_STEP:  state_next = S_STEP;
            OP_CLEAR: clear_go   = 1'b1;
            default:  ;  // STOP while idle has nothing to stop
          endcase
        end
      end

      S_RUN: begin
        bp_skip_next = 1'b0;
        cpu_en       = !stop_now;
        if (stop_now) begin
          done_next  = 1'b1;
          state_next = bus.cpu_halted ? S_HALTED : S_IDLE;
          if (bus.cpu_halted)  done_cause_next = CAUSE_HALT;
          else if (bp_hit)     done_cause_next = CAUSE_BP;
          else if (timeout_hit) done_cause_next = CAUSE_TO;
          else                 done_cause_next = CAUSE_STOP;
        end else begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end
      end

      S_STEP: begin
        cpu_en          = !bus.cpu_halted;
        done_next       = 1'b1;
        state_next      = bus.cpu_halted ? S_HALTED : S_IDLE;
        done_cause_next = bus.cpu_halted ? CAUSE_HALT : CAUSE_STOP;
      end

      S_HALTED: begin
        if (cmd_fire && (bus.cmd_op == OP_CLEAR)) begin
          state_next = S_IDLE;
          clear_go   = 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.cpu_en     = cpu_en;
  assign bus.cpu_rst    = cpu_rst_reg;
  assign bus.state      = state_reg;
  assign bus.cycle_cnt  = cycle_cnt_reg;
  assign bus.done       = done_reg;
  assign bus.done_cause = done_cause_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl. A tiny PC model
// advances on cpu_en and returns to 0 on cpu_rst. Inputs change on the
// falling edge and outputs are sampled there (or 1ns later after an input
// change), away from the active rising edge.
module tb_cpu_run_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] pc;

  cpu_run_ctrl_if #(.PC_W(8), .CNT_W(16)) bus ();

  cpu_run_ctrl #(.PC_W(8), .CNT_W(16), .TIMEOUT(50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc <= 8'd0;
    else if (bus.cpu_rst) pc <= 8'd0;
    else if (bus.cpu_en)  pc <= pc + 8'd1;
  end
  assign bus.cpu_pc = pc;

  task automatic send(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0;
    bus.bp_en = 1'b0; bus.bp_addr = 8'd0; bus.cpu_halted = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_en got %b exp 0", bus.cpu_en); end
    n_tests++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst got %b exp 1", bus.cpu_rst); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.done); end
    n_tests++; if (bus.done_cause !== 2'd0) begin n_fail++; $display("FAIL rst_cause got %0d exp 0", bus.done_cause); end
    n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", bus.cycle_cnt); end
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.cmd_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.cpu_rst !== 1'b0) begin n_fail++; $display("FAIL rst_release_cpu_rst got %b exp 0", bus.cpu_rst); end
    $display("[TB] reset done");
  endtask

  task automatic test_halt();
    send(2'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL halt_run_state got %0d exp 1", bus.state); end
    n_tests++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL halt_first_en got %b exp 1", bus.cpu_en); end
    repeat (5) @(negedge clk);
    @(negedge clk);
    bus.cpu_halted = 1'b1;
    #1;
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_en_on_halt got %b exp 0", bus.cpu_en); end
    @(negedge clk);
    n_tests++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL halt_state got %0d exp 3", bus.state); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL halt_done got %b exp 1", bus.done); end
    n_tests++; if (bus.done_cause !== 2'd0) begin n_fail++; $display("FAIL halt_cause got %0d exp 0", bus.done_cause); end
    n_tests++; if (bus.cycle_cnt !== 16'd6) begin n_fail++; $display("FAIL halt_cnt got %0d exp 6", bus.cycle_cnt); end
    send(2'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL halt_done_width got %b exp 0", bus.done); end
    @(negedge clk);
    n_tests++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL halt_run_dropped got %0d exp 3", bus.state); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL halt_no_done got %b exp 0", bus.done); end
    $display("[TB] run until halt done");
  endtask

  task automatic test_clear();
    bus.cpu_halted = 1'b0;
    send(2'd3);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL clr_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL clr_cpu_rst got %b exp 1", bus.cpu_rst); end
    n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_cnt got %0d exp 0", bus.cycle_cnt); end
    @(negedge clk);
    n_tests++; if (bus.cpu_rst !== 1'b0) begin n_fail++; $display("FAIL clr_cpu_rst_width got %b exp 0", bus.cpu_rst); end
    $display("[TB] clear from halted done");
  endtask

  task automatic test_breakpoint();
    bus.bp_en = 1'b1; bus.bp_addr = 8'h04;
    send(2'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL bp_en_at_hit got %b exp 0", bus.cpu_en); end
    @(negedge clk);
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL bp_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b exp 1", bus.done); end
    n_tests++; if (bus.done_cause !== 2'd1) begin n_fail++; $display("FAIL bp_cause got %0d exp 1", bus.done_cause); end
    n_tests++; if (bus.cycle_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_cnt got %0d exp 4", bus.cycle_cnt); end
    send(2'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume_en got %b exp 1", bus.cpu_en); end
    @(negedge clk);
    n_tests++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume_en2 got %b exp 1", bus.cpu_en); end
    @(negedge clk);
    send(2'd2);
    #1;
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL stop_en_accept got %b exp 0", bus.cpu_en); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.bp_en = 1'b0;
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL stop_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL stop_done got %b exp 1", bus.done); end
    n_tests++; if (bus.done_cause !== 2'd3) begin n_fail++; $display("FAIL stop_cause got %0d exp 3", bus.done_cause); end
    n_tests++; if (bus.cycle_cnt !== 16'd6) begin n_fail++; $display("FAIL stop_cnt got %0d exp 6", bus.cycle_cnt); end
    $display("[TB] breakpoint, resume and stop done");
  endtask

  task automatic test_stop_with_halt();
    send(2'd0);
    @(negedge clk);
    send(2'd2);
    bus.cpu_halted = 1'b1;
    #1;
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL sh_en got %b exp 0", bus.cpu_en); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL sh_state got %0d exp 3", bus.state); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL sh_done got %b exp 1", bus.done); end
    n_tests++; if (bus.done_cause !== 2'd0) begin n_fail++; $display("FAIL sh_cause got %0d exp 0", bus.done_cause); end
    bus.cpu_halted = 1'b0;
    send(2'd3);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL sh_clr_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL sh_clr_cnt got %0d exp 0", bus.cycle_cnt); end
    @(negedge clk);
    $display("[TB] stop with halt done");
  endtask

  task automatic test_back_to_back_steps();
    for (int s = 0; s < 3; s++) begin
      send(2'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_tests++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL step%0d_state got %0d exp 2", s, bus.state); end
      n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL step%0d_ready got %b exp 0", s, bus.cmd_ready); end
      n_tests++; if (bus.cpu_en !== 1'b1) begin n_fail++; $display("FAIL step%0d_en got %b exp 1", s, bus.cpu_en); end
      @(negedge clk);
      n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL step%0d_done got %b exp 1", s, bus.done); end
      n_tests++; if (bus.done_cause !== 2'd3) begin n_fail++; $display("FAIL step%0d_cause got %0d exp 3", s, bus.done_cause); end
      n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL step%0d_idle got %0d exp 0", s, bus.state); end
    end
    n_tests++; if (bus.cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL step_cnt got %0d exp 3", bus.cycle_cnt); end
    send(2'd3);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_tests++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL idle_clr_rst got %b exp 1", bus.cpu_rst); end
    n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL idle_clr_cnt got %0d exp 0", bus.cycle_cnt); end
    n_tests++; if (bus.done_cause !== 2'd3) begin n_fail++; $display("FAIL idle_clr_cause got %0d exp 3", bus.done_cause); end
    @(negedge clk);
    $display("[TB] three steps and idle clear done");
  endtask

  task automatic test_timeout();
    int  en_count;
    bit  seen;
    en_count = 0;
    seen = 1'b0;
    send(2'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.cpu_en === 1'b1) en_count++;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL to_done_seen got 0 exp 1 within 200 cycles"); end
    n_tests++; if (en_count != 50) begin n_fail++; $display("FAIL to_en_count got %0d exp 50", en_count); end
    n_tests++; if (bus.done_cause !== 2'd2) begin n_fail++; $display("FAIL to_cause got %0d exp 2", bus.done_cause); end
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL to_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.cycle_cnt !== 16'd50) begin n_fail++; $display("FAIL to_cnt got %0d exp 50", bus.cycle_cnt); end
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL to_done_width got %b exp 0", bus.done); end
    $display("[TB] timeout run done, %0d instructions", en_count);
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    done_seen = 0;
    send(2'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL mid_state got %0d exp 0", bus.state); end
    n_tests++; if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL mid_en got %b exp 0", bus.cpu_en); end
    n_tests++; if (bus.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_rst got %b exp 1", bus.cpu_rst); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b exp 0", bus.done); end
    n_tests++; if (bus.done_cause !== 2'd0) begin n_fail++; $display("FAIL mid_cause got %0d exp 0", bus.done_cause); end
    n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got %0d exp 0", bus.cycle_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL mid_no_done got %0d pulses exp 0", done_seen); end
    n_tests++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL mid_after_state got %0d exp 0", bus.state); end
    $display("[TB] reset mid-run done");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_halt();
    test_clear();
    test_breakpoint();
    test_stop_with_halt();
    test_back_to_back_steps();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
